// File: rtl/brush_motor_encoder.sv
// Quadrature encoder interface with an Avalon-MM register bank: synchronised and glitch-filtered
// A/B inputs, 4x decode, a 32-bit position counter and a windowed speed measurement.
module brush_motor_encoder (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  input  logic        QA,
  input  logic        QB
);

  localparam logic [31:0] ID_VALUE    = 32'hEA68_0003;
  localparam logic [31:0] WIN_DEFAULT = 32'd50000;
  localparam logic [31:0] ACC_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] ACC_MIN     = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  assign clk   = csi_MCLK_clk;
  assign rst_n = rsi_MRST_reset_n;

  logic        en_reg;
  logic        inv_reg;
  logic [7:0]  flt_reg;
  logic [31:0] pos_reg;
  logic [31:0] win_reg;
  logic [31:0] spd_reg;
  logic [31:0] timer_reg;
  logic [31:0] acc_reg;
  logic        dir_reg;
  logic        err_reg;
  logic        vld_reg;
  logic [1:0]  prev_ab_reg;
  logic [31:0] readdata_reg;

  logic [1:0]  q_raw;
  logic [1:0]  filt_ab;
  assign q_raw = {QA, QB};

  // Bit 1 carries channel A, bit 0 channel B.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic       sync1_reg;
      logic       sync2_reg;
      logic       filt_reg;
      logic [7:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          filt_reg  <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= q_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != filt_reg) begin
            if (cnt_reg == flt_reg) begin
              filt_reg <= sync2_reg;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign filt_ab[gi] = filt_reg;
    end
  endgenerate

  logic step_up;
  logic step_dn;
  logic step_bad;
  logic step_fwd;
  logic step_rev;

  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    step_bad = 1'b0;
    unique case ({prev_ab_reg, filt_ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up  = 1'b1;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_dn  = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
      default: ;
    endcase
    step_fwd = inv_reg ? step_dn : step_up;
    step_rev = inv_reg ? step_up : step_dn;
  end

  logic wr_ctrl;
  logic wr_win;
  logic wr_stat;
  logic clr_pulse;
  logic err_w1c;
  assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == 3'd0);
  assign wr_win    = avs_ctrl_write && (avs_ctrl_address == 3'd3);
  assign wr_stat   = avs_ctrl_write && (avs_ctrl_address == 3'd5);
  assign clr_pulse = wr_ctrl && avs_ctrl_byteenable[0] && avs_ctrl_writedata[1];
  assign err_w1c   = wr_stat && avs_ctrl_byteenable[0] && avs_ctrl_writedata[1];

  logic [31:0] acc_sum;
  always_comb begin
    acc_sum = acc_reg;
    if (step_fwd && (acc_reg != ACC_MAX)) begin
      acc_sum = acc_reg + 32'd1;
    end else if (step_rev && (acc_reg != ACC_MIN)) begin
      acc_sum = acc_reg - 32'd1;
    end
  end

  logic win_terminal;
  assign win_terminal = (timer_reg >= (win_reg - 32'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg      <= 1'b0;
      inv_reg     <= 1'b0;
      flt_reg     <= '0;
      pos_reg     <= '0;
      win_reg     <= WIN_DEFAULT;
      spd_reg     <= '0;
      timer_reg   <= '0;
      acc_reg     <= '0;
      dir_reg     <= 1'b0;
      err_reg     <= 1'b0;
      vld_reg     <= 1'b0;
      prev_ab_reg <= 2'b00;
    end else begin
      prev_ab_reg <= filt_ab;

      if (wr_ctrl) begin
        if (avs_ctrl_byteenable[0]) begin
          en_reg  <= avs_ctrl_writedata[0];
          inv_reg <= avs_ctrl_writedata[2];
        end
        if (avs_ctrl_byteenable[1]) begin
          flt_reg <= avs_ctrl_writedata[15:8];
        end
      end

      if (wr_win) begin
        for (int b = 0; b < 4; b++) begin
          if (avs_ctrl_byteenable[b]) begin
            win_reg[8*b +: 8] <= avs_ctrl_writedata[8*b +: 8];
          end
        end
      end

      // Clear has priority over a step decoded in the same cycle.
      if (clr_pulse) begin
        pos_reg <= '0;
      end else if (en_reg && step_fwd) begin
        pos_reg <= pos_reg + 32'd1;
      end else if (en_reg && step_rev) begin
        pos_reg <= pos_reg - 32'd1;
      end

      if (step_fwd) begin
        dir_reg <= 1'b0;
      end else if (step_rev) begin
        dir_reg <= 1'b1;
      end

      if (step_bad) begin
        err_reg <= 1'b1;
      end else if (err_w1c) begin
        err_reg <= 1'b0;
      end

      if (wr_win) begin
        timer_reg <= '0;
        acc_reg   <= '0;
      end else if (en_reg && (win_reg != 32'd0)) begin
        if (win_terminal) begin
          spd_reg   <= acc_sum;
          acc_reg   <= '0;
          timer_reg <= '0;
          vld_reg   <= 1'b1;
        end else begin
          acc_reg   <= acc_sum;
          timer_reg <= timer_reg + 32'd1;
        end
      end
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    unique case (avs_ctrl_address)
      3'd0:    rd_mux = {16'h0000, flt_reg, 5'b00000, inv_reg, 1'b0, en_reg};
      3'd1:    rd_mux = ID_VALUE;
      3'd2:    rd_mux = pos_reg;
      3'd3:    rd_mux = win_reg;
      3'd4:    rd_mux = spd_reg;
      3'd5:    rd_mux = {29'd0, vld_reg, err_reg, dir_reg};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_reg <= '0;
    end else if (avs_ctrl_read) begin
      readdata_reg <= rd_mux;
    end
  end

  assign avs_ctrl_readdata    = readdata_reg;
  assign avs_ctrl_waitrequest = 1'b0;

endmodule

// File: doc/brush_motor_encoder.md
BRUSH_MOTOR_ENCODER -- requirements
Module: brush_motor_encoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL provide these ports:
- csi_MCLK_clk  in  1  system clock.
- rsi_MRST_reset_n  in  1  async active-low reset.
- avs_ctrl_writedata  in  32  Avalon-MM write data.
- avs_ctrl_readdata  out  32  Avalon-MM read data.
- avs_ctrl_byteenable  in  4  write byte lanes.
- avs_ctrl_address  in  3  word address.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_read  in  1  read strobe.
- avs_ctrl_waitrequest  out  1  tied 0.
- QA  in  1  encoder channel A, asynchronous.
- QB  in  1  encoder channel B, asynchronous.
REQ-003 The block SHALL implement this register map (name, reset default, meaning):
- 0 CTRL, 0x0000_0000: bit0 EN; bit1 CLR (write-1 pulse, reads 0); bit2 INV direction; [15:8] FLT filter length.
- 1 ID, 0xEA68_0003: read-only identifier.
- 2 POS, 0: signed position, read-only.
- 3 WIN, 50000: speed window in clocks; 0 disables speed sampling.
- 4 SPD, 0: signed edge count of the last completed window, read-only.
- 5 STAT, 0: bit0 DIR (1 = reverse); bit1 ERR (sticky, write-1-to-clear); bit2 VLD (at least one window completed).
- 6, 7: read 0; writes ignored.

Function
REQ-004 Writes SHALL update only the byte lanes enabled by avs_ctrl_byteenable; writes to read-only fields SHALL be ignored.
REQ-005 On a read, avs_ctrl_readdata SHALL be registered and valid the cycle after avs_ctrl_read; otherwise it SHALL hold its last value.
REQ-006 QA and QB SHALL each pass through a 2-flop synchronizer.
REQ-007 After synchronization, each channel SHALL pass through a glitch filter:
- a per-channel counter increments while the synced value differs from the filtered value, and clears when they are equal;
- the filtered value takes the synced value when the counter equals FLT.
- Input-to-filtered latency SHALL therefore be 2+FLT+1 clocks; FLT=0 gives 3 clocks.
REQ-008 Decode SHALL be 4x, comparing the previous and current filtered {A,B} each clock:
- 00->01->11->10->00 SHALL give +1;
- the reverse sequence SHALL give -1;
- no change SHALL give 0;
- both bits changing SHALL give 0 and set ERR.
REQ-009 INV=1 SHALL negate the decoded step.
REQ-010 DIR SHALL hold the sign of the last nonzero step.
REQ-011 With EN=1, POS SHALL add the step each clock with 32-bit two's-complement wrap (0x7FFFFFFF+1 = 0x80000000).
REQ-012 With EN=0, POS, the window timer and the accumulator SHALL hold; the filter and decode SHALL keep tracking so that no false step occurs when EN is raised.
REQ-013 A CTRL write with CLR=1 SHALL zero POS the next clock; if a step occurs in the same cycle, CLR SHALL win.
REQ-014 The speed function SHALL work as follows when EN=1 and WIN≠0:
- the timer counts 0..WIN-1;
- the accumulator adds each step, saturating at 0x7FFFFFFF / 0x80000000;
- on the terminal count, SPD takes the accumulator value including that cycle's step, then the accumulator and timer clear and VLD sets.
REQ-015 Any write to WIN SHALL clear the timer and the accumulator; SPD and VLD SHALL hold.
REQ-016 A write-1 to STAT bit1 in the same cycle as a new error SHALL leave ERR=1 (set wins).

Reset
REQ-017 While rsi_MRST_reset_n=0 the block SHALL drive:
- avs_ctrl_readdata=0 and avs_ctrl_waitrequest=0;
- all registers to the defaults in REQ-003;
- synchronizers, filtered values and previous state to 00, and filter counters, timer and accumulator to 0.
REQ-018 Reset asserted mid-window or mid-filter SHALL discard partial counts; the first post-reset input change SHALL follow the REQ-007 latency.

Verification
REQ-019 Reset release, read addr1 -> 0xEA680003 one clock later; addr3 -> 50000; addr2 -> 0.
REQ-020 EN=1, FLT=0, 8 forward quadrature edges, 10 clocks apart -> POS=8, DIR=0; set INV=1, 8 more forward edges -> POS=0, DIR=1.
REQ-021 FLT=4, 3-clock glitch on QA -> POS unchanged; 6-clock-stable change on QA -> POS increments after 2+5 clocks.
REQ-022 QA and QB toggled together -> ERR=1, POS unchanged; write STAT=0x2 -> ERR=0.
REQ-023 WIN=100, forward edge every 10 clocks -> SPD=10, VLD=1 after first window; with POS=0x7FFFFFFF, one forward edge -> POS=0x80000000.
REQ-024 CLR written in the same cycle as a decoded edge -> POS=0; reset asserted mid-window -> SPD=0, VLD=0.
